// File: rtl/task_dispatch_sched.sv
// Task sequencer: queues A/B task arrivals, dispatches them round-robin to idle machines,
// and counts execution ticks per machine, flagging arrivals lost to a full queue.
module task_dispatch_sched #(
  parameter int NMACH      = 2,
  parameter int QDEPTH     = 4,
  parameter int DUR_A      = 2,
  parameter int DUR_B      = 3,
  parameter int EXTRA      = 1,
  parameter int SEL_BIT    = 0,
  parameter int STATE_WRAP = 64,
  localparam int MW = (NMACH > 1) ? $clog2(NMACH) : 1,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_type,
  output logic             req_ready,
  input  logic             tick,
  output logic             disp_valid,
  output logic [MW-1:0]    disp_mach,
  output logic             disp_type,
  output logic [NMACH-1:0] mach_busy,
  output logic [NMACH-1:0] done,
  output logic [CW-1:0]    q_level,
  output logic             error
);

  localparam int PW   = $clog2(QDEPTH);
  localparam int DMAX = (DUR_A > DUR_B) ? DUR_A : DUR_B;
  localparam int RW   = $clog2(DMAX + EXTRA + 1);
  localparam int SW   = $clog2(STATE_WRAP + 1);

  logic          mem [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] level_nxt;
  logic [MW-1:0] rr_ptr, pick_idx, rr_nxt;
  logic          pick_found;
  logic          push, pop, head_type;

  logic [RW-1:0] rem   [NMACH];
  logic [SW-1:0] state [NMACH];

  assign push      = req_valid && req_ready;
  assign pop       = (q_level != '0) && pick_found;
  assign head_type = mem[rd_ptr];

  // Round-robin search: first idle machine at or after rr_ptr, wrapping modulo NMACH.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_nxt     = rr_ptr;
    for (int k = 0; k < NMACH; k++) begin
      for (int i = 0; i < NMACH; i++) begin
        if (!pick_found && (i == (int'(rr_ptr) + k) % NMACH) && !mach_busy[i]) begin
          pick_found = 1'b1;
          pick_idx   = MW'(i);
          rr_nxt     = MW'((i + 1) % NMACH);
        end
      end
    end
  end

  always_comb begin
    level_nxt = q_level;
    if (push && !pop)      level_nxt = q_level + CW'(1);
    else if (pop && !push) level_nxt = q_level - CW'(1);
  end

  // NOTE: the FIFO storage has no reset; occupancy and pointers alone define which entries
  // are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_type;
  end

  // NOTE: all state registers use non-blocking assignment so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_level    <= '0;
      req_ready  <= 1'b1;
      rr_ptr     <= '0;
      disp_valid <= 1'b0;
      disp_mach  <= '0;
      disp_type  <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      q_level    <= level_nxt;
      req_ready  <= (level_nxt != CW'(QDEPTH));
      disp_valid <= pop;
      if (pop) begin
        disp_mach <= pick_idx;
        disp_type <= head_type;
        rr_ptr    <= rr_nxt;
      end
      if (req_valid && !req_ready) error <= 1'b1;
    end
  end

  // Busy machines consume ticks; an idle machine can only be loaded by a dispatch, so the
  // two never act on the same machine in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mach_busy <= '0;
      done      <= '0;
      for (int i = 0; i < NMACH; i++) begin
        rem[i]   <= '0;
        state[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NMACH; i++) begin
        done[i] <= 1'b0;
        if (mach_busy[i]) begin
          if (tick) begin
            rem[i]   <= rem[i] - RW'(1);
            state[i] <= (state[i] == SW'(STATE_WRAP)) ? '0 : state[i] + SW'(1);
            if (rem[i] == RW'(1)) begin
              mach_busy[i] <= 1'b0;
              done[i]      <= 1'b1;
            end
          end
        end else if (pop && (pick_idx == MW'(i))) begin
          mach_busy[i] <= 1'b1;
          rem[i]       <= (head_type ? RW'(DUR_B) : RW'(DUR_A)) +
                          (state[i][SEL_BIT] ? RW'(EXTRA) : '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_task_dispatch_sched.sv
// Bench for task_dispatch_sched: queue/array reference model compared every cycle under
// directed scenarios and randomized arrivals/ticks, including asynchronous mid-run resets.
module tb_task_dispatch_sched;

  localparam int NMACH      = 2;
  localparam int QDEPTH     = 4;
  localparam int DUR_A      = 2;
  localparam int DUR_B      = 3;
  localparam int EXTRA      = 1;
  localparam int SEL_BIT    = 0;
  localparam int STATE_WRAP = 64;
  localparam int MW = (NMACH > 1) ? $clog2(NMACH) : 1;
  localparam int CW = $clog2(QDEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_type = 1'b0;
  logic             tick = 1'b0;
  logic             req_ready;
  logic             disp_valid;
  logic [MW-1:0]    disp_mach;
  logic             disp_type;
  logic [NMACH-1:0] mach_busy;
  logic [NMACH-1:0] done;
  logic [CW-1:0]    q_level;
  logic             error;

  task_dispatch_sched #(
    .NMACH(NMACH), .QDEPTH(QDEPTH), .DUR_A(DUR_A), .DUR_B(DUR_B),
    .EXTRA(EXTRA), .SEL_BIT(SEL_BIT), .STATE_WRAP(STATE_WRAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_type(req_type),
    .req_ready(req_ready), .tick(tick), .disp_valid(disp_valid), .disp_mach(disp_mach),
    .disp_type(disp_type), .mach_busy(mach_busy), .done(done), .q_level(q_level),
    .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending tasks as a queue of types, machines as plain integer arrays.
  bit   mq[$];
  bit   m_busy  [NMACH];
  int   m_rem   [NMACH];
  int   m_state [NMACH];
  bit   m_done  [NMACH];
  int   m_rr;
  bit   m_err;
  bit   m_dv;
  int   m_dm;
  bit   m_dt;

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < NMACH; i++) begin
      m_busy[i] = 0; m_rem[i] = 0; m_state[i] = 0; m_done[i] = 0;
    end
    m_rr = 0; m_err = 0; m_dv = 0; m_dm = 0; m_dt = 0;
  endfunction

  function automatic void model_edge(input bit v, input bit ty, input bit tk);
    int pick = -1;
    int pre_size = mq.size();
    bit head = 0;
    bit was_busy [NMACH];
    was_busy = m_busy;
    m_dv = 0;
    for (int i = 0; i < NMACH; i++) m_done[i] = 0;
    if (pre_size > 0) begin
      for (int k = 0; k < NMACH; k++) begin
        int cand = (m_rr + k) % NMACH;
        if (pick < 0 && !m_busy[cand]) pick = cand;
      end
    end
    if (pick >= 0) begin
      head = mq.pop_front();
      m_dv = 1; m_dm = pick; m_dt = head;
      m_rr = (pick + 1) % NMACH;
    end
    if (tk) begin
      for (int i = 0; i < NMACH; i++) begin
        if (was_busy[i]) begin
          m_rem[i]--;
          m_state[i] = (m_state[i] == STATE_WRAP) ? 0 : m_state[i] + 1;
          if (m_rem[i] == 0) begin
            m_busy[i] = 0;
            m_done[i] = 1;
          end
        end
      end
    end
    if (pick >= 0) begin
      m_busy[pick] = 1;
      m_rem[pick]  = (head ? DUR_B : DUR_A) + (((m_state[pick] >> SEL_BIT) & 1) ? EXTRA : 0);
    end
    if (v) begin
      if (pre_size < QDEPTH) mq.push_back(ty);
      else m_err = 1;
    end
  endfunction

  task automatic compare_all();
    check("req_ready", req_ready, int'(mq.size() < QDEPTH));
    check("q_level", q_level, mq.size());
    check("disp_valid", disp_valid, m_dv);
    if (m_dv) begin
      check("disp_mach", disp_mach, m_dm);
      check("disp_type", disp_type, m_dt);
    end
    for (int i = 0; i < NMACH; i++) begin
      check("mach_busy", mach_busy[i], m_busy[i]);
      check("done", done[i], m_done[i]);
    end
    check("error", error, m_err);
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit v, input bit ty, input bit tk);
    req_valid = v; req_type = ty; tick = tk;
    @(posedge clk);
    model_edge(v, ty, tk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("rst_q_level", q_level, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", mach_busy, 0);
    check("rst_done", done, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_error", error, 0);
    req_valid = 1; tick = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_done", done, 0);
    check("rst_hold_level", q_level, 0);
    req_valid = 0; tick = 0; req_type = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    // Single A task: dispatch one cycle after acceptance, two ticks to finish.
    do_reset();
    step(1, 0, 0);
    check("lit1_level", q_level, 1);
    step(0, 0, 0);
    check("lit1_dv", disp_valid, 1);
    check("lit1_mach", disp_mach, 0);
    check("lit1_type", disp_type, 0);
    check("lit1_level0", q_level, 0);
    step(0, 0, 1);
    check("lit1_busy", mach_busy, 2'b01);
    step(0, 0, 1);
    check("lit1_done", done, 2'b01);
    check("lit1_idle", mach_busy, 2'b00);
    check("lit1_state0", m_state[0], 2);

    // A, B, then a third task that waits for the first machine to free up.
    do_reset();
    step(1, 0, 0);
    step(1, 1, 0);
    check("lit2_dv_a", disp_mach, 0);
    step(1, 0, 0);
    check("lit2_mach_b", disp_mach, 1);
    check("lit2_type_b", disp_type, 1);
    step(0, 0, 0);
    check("lit2_level", q_level, 1);
    check("lit2_busy", mach_busy, 2'b11);
    step(0, 0, 1);
    step(0, 0, 1);
    check("lit2_done", done, 2'b01);
    check("lit2_still_q", q_level, 1);
    check("lit2_no_disp", disp_valid, 0);
    step(0, 0, 0);
    check("lit2_dv3", disp_valid, 1);
    check("lit2_mach3", disp_mach, 0);
    check("lit2_level0", q_level, 0);

    // Fill the queue with no ticks; the seventh arrival is dropped.
    do_reset();
    repeat (5) step(1, 0, 0);
    check("lit3_level", q_level, 3);
    check("lit3_ready", req_ready, 1);
    step(1, 0, 0);
    check("lit3_full", q_level, 4);
    check("lit3_notready", req_ready, 0);
    check("lit3_noerr", error, 0);
    step(1, 0, 0);
    check("lit3_err", error, 1);
    step(0, 0, 0);
    check("lit3_sticky", error, 1);

    // B on machine 0 with state0 odd takes DUR_B+EXTRA ticks.
    do_reset();
    step(1, 1, 0);
    step(0, 0, 0);
    repeat (3) step(0, 0, 1);
    check("lit4_state0", m_state[0], 3);
    step(1, 1, 0);
    step(1, 1, 0);
    check("lit4_first_m1", disp_mach, 1);
    step(0, 0, 0);
    check("lit4_mach0", disp_mach, 0);
    repeat (3) step(0, 0, 1);
    check("lit4_busy_3", mach_busy[0], 1);
    step(0, 0, 1);
    check("lit4_done_4", done[0], 1);

    // Mid-task reset with two tasks queued.
    do_reset();
    repeat (4) step(1, 0, 0);
    step(0, 0, 1);
    check("lit5_level", q_level, 2);
    do_reset();
    step(0, 0, 1);
    check("lit5_ready", req_ready, 1);

    // Randomized traffic with periodic asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      step($urandom_range(0, 99) < 45, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
